// File: rtl/vec_pkg.sv
// vec_pkg: shared definitions for the vector load writeback slice.
//   wb_state_e : writeback sequencer states
//   VREG_AW    : vector register address width (32 registers)
//   sew_bytes  : element width in bytes (8->1, 16->2, anything else->4)
package vec_pkg;

  localparam int VREG_AW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_e;

  function automatic logic [2:0] sew_bytes(input logic [6:0] sew);
    case (sew)
      7'd8:    sew_bytes = 3'd1;
      7'd16:   sew_bytes = 3'd2;
      default: sew_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/vec_ld_wb_if.sv
// vec_ld_wb_if: load-unit side, register-file side and status signals of the
// load writeback sequencer.
//   master : load unit / register file / controller (drives load + vrf_ready)
//   slave  : the sequencer (drives vrf_wr_* and wb_busy/wb_done)
interface vec_ld_wb_if
  import vec_pkg::*;
#(
  parameter int VLEN     = 512,
  parameter int MAX_VLEN = 4096
);
  logic                 is_loaded;
  logic [MAX_VLEN-1:0]  vd_data;
  logic [VREG_AW-1:0]   vd_addr;
  logic [1:0]           emul;
  logic [9:0]           vl;
  logic [6:0]           sew;
  logic                 vrf_ready;
  logic                 vrf_wr_en;
  logic [VREG_AW-1:0]   vrf_wr_addr;
  logic [VLEN-1:0]      vrf_wr_data;
  logic [VLEN/8-1:0]    vrf_wr_be;
  logic                 wb_busy;
  logic                 wb_done;

  modport master (
    output is_loaded, vd_data, vd_addr, emul, vl, sew, vrf_ready,
    input  vrf_wr_en, vrf_wr_addr, vrf_wr_data, vrf_wr_be, wb_busy, wb_done
  );

  modport slave (
    input  is_loaded, vd_data, vd_addr, emul, vl, sew, vrf_ready,
    output vrf_wr_en, vrf_wr_addr, vrf_wr_data, vrf_wr_be, wb_busy, wb_done
  );
endinterface

// File: rtl/vec_wb_be_gen.sv
// vec_wb_be_gen: byte enables for one register of a load group.
//   idx_i : register index within the group
//   vl_i  : active element count
//   sew_i : element width in bits
//   be_o  : byte b enabled iff idx*(VLEN/8) + b < vl*sew_bytes(sew)
module vec_wb_be_gen
  import vec_pkg::*;
#(
  parameter int VLEN = 512
) (
  input  logic [2:0]        idx_i,
  input  logic [9:0]        vl_i,
  input  logic [6:0]        sew_i,
  output logic [VLEN/8-1:0] be_o
);
  localparam int NB = VLEN / 8;

  // vl*sew_bytes reaches 4092, so 13 bits keeps the compare exact.
  logic [12:0] limit;
  assign limit = 13'(vl_i) * 13'(sew_bytes(sew_i));

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign be_o[b] = (13'(idx_i) * 13'(NB) + 13'(b)) < limit;
  end
endmodule

// File: rtl/vec_ld_wb.sv
// vec_ld_wb: vector load writeback sequencer.
// On a rising edge of is_loaded (while idle) the full load vector and its
// destination info are captured, then written one VLEN register per cycle
// into the aligned register group, honouring vrf_ready backpressure.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vec_ld_wb_if.slave (load inputs, vrf write port, busy/done)
// Build option: VEC_WB_TAIL_MASK_EN masks tail bytes at or beyond vl;
// without it every write has all byte enables set.
module vec_ld_wb
  import vec_pkg::*;
#(
  parameter int VLEN     = 512,
  parameter int MAX_VLEN = 4096
) (
  input  logic         clk,
  input  logic         rst,
  vec_ld_wb_if.slave   bus
);
  localparam int NB = VLEN / 8;

  wb_state_e            state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic                 ld_q;
  logic [MAX_VLEN-1:0]  buf_q, buf_d;
  logic [VREG_AW-1:0]   base_q, base_d;
  logic [1:0]           emul_q, emul_d;
`ifdef VEC_WB_TAIL_MASK_EN
  logic [9:0]           vl_q, vl_d;
  logic [6:0]           sew_q, sew_d;
`endif

  logic start, last, wr;

  // ld_q clears in reset, so a level already high at release reads as an edge.
  assign start = bus.is_loaded & ~ld_q;
  assign last  = idx_q == 3'((4'd1 << emul_q) - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ld_q    <= 1'b0;
      buf_q   <= '0;
      base_q  <= '0;
      emul_q  <= '0;
`ifdef VEC_WB_TAIL_MASK_EN
      vl_q    <= '0;
      sew_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ld_q    <= bus.is_loaded;
      buf_q   <= buf_d;
      base_q  <= base_d;
      emul_q  <= emul_d;
`ifdef VEC_WB_TAIL_MASK_EN
      vl_q    <= vl_d;
      sew_q   <= sew_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    base_d  = base_q;
    emul_d  = emul_q;
`ifdef VEC_WB_TAIL_MASK_EN
    vl_d    = vl_q;
    sew_d   = sew_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          buf_d   = bus.vd_data;
          // Clearing the low emul bits aligns the group; it never wraps past v31.
          base_d  = bus.vd_addr & ~VREG_AW'((6'd1 << bus.emul) - 6'd1);
          emul_d  = bus.emul;
`ifdef VEC_WB_TAIL_MASK_EN
          vl_d    = bus.vl;
          sew_d   = bus.sew;
`endif
          idx_d   = '0;
          state_d = (bus.vl == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (bus.vrf_ready) begin
          if (last) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while rst is asserted, not just after it lands.
  assign wr              = (state_q == WRITE) & ~rst;
  assign bus.vrf_wr_en   = wr;
  assign bus.vrf_wr_addr = wr ? base_q + {2'b00, idx_q} : '0;
  assign bus.vrf_wr_data = wr ? buf_q[idx_q*VLEN +: VLEN] : '0;
  assign bus.wb_busy     = (state_q != IDLE) & ~rst;
  assign bus.wb_done     = (state_q == DONE) & ~rst;

`ifdef VEC_WB_TAIL_MASK_EN
  logic [NB-1:0] be_tail;
  vec_wb_be_gen #(.VLEN(VLEN)) u_be_gen (
    .idx_i (idx_q),
    .vl_i  (vl_q),
    .sew_i (sew_q),
    .be_o  (be_tail)
  );
  assign bus.vrf_wr_be = wr ? be_tail : '0;
`else
  assign bus.vrf_wr_be = {NB{wr}};
`endif
endmodule

// File: tb/tb_vec_ld_wb.sv
// tb_vec_ld_wb: scoreboard bench for vec_ld_wb. Stimulus pushes expected
// writes/done pulses (with their cycle) into a queue; a negedge monitor pops
// and compares whenever the DUT presents an accepted write or wb_done, and
// checks that stalled writes hold addr/data/be.
module tb_vec_ld_wb;
  import vec_pkg::*;

  localparam int VLEN = 512;
  localparam int MAXV = 4096;
  localparam int NB   = VLEN / 8;
  localparam logic [NB-1:0] ALL = {NB{1'b1}};
`ifdef VEC_WB_TAIL_MASK_EN
  localparam logic [NB-1:0] BE_V20 = 64'h0000_0000_0000_FFFF;
  localparam logic [NB-1:0] BE_10B = 64'h0000_0000_0000_03FF;
  localparam logic [NB-1:0] BE_12B = 64'h0000_0000_0000_0FFF;
`else
  localparam logic [NB-1:0] BE_V20 = ALL;
  localparam logic [NB-1:0] BE_10B = ALL;
  localparam logic [NB-1:0] BE_12B = ALL;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_ld_wb_if #(.VLEN(VLEN), .MAX_VLEN(MAXV)) bus ();

  vec_ld_wb #(.VLEN(VLEN), .MAX_VLEN(MAXV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit                is_done;
    int                cyc;
    logic [4:0]        addr;
    logic [VLEN-1:0]   data;
    logic [NB-1:0]     be;
  } exp_t;
  exp_t q[$];

  // Register r of a load group: 16 words tagged with seed, r and word index.
  function automatic logic [VLEN-1:0] pat(input logic [7:0] seed, input int r);
    logic [VLEN-1:0] v;
    for (int w = 0; w < VLEN/32; w++) v[w*32 +: 32] = {seed, 8'(r), 8'(w), 8'hC3};
    return v;
  endfunction

  function automatic logic [MAXV-1:0] mkvec(input logic [7:0] seed);
    logic [MAXV-1:0] v;
    for (int r = 0; r < 8; r++) v[r*VLEN +: VLEN] = pat(seed, r);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int c, input logic [4:0] a, input logic [VLEN-1:0] d,
                         input logic [NB-1:0] be);
    exp_t e;
    e.is_done = 1'b0; e.cyc = c; e.addr = a; e.data = d; e.be = be;
    q.push_back(e);
  endtask

  task automatic push_done(input int c);
    exp_t e;
    e.is_done = 1'b1; e.cyc = c; e.addr = '0; e.data = '0; e.be = '0;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Raise is_loaded with the given load; t is the edge cycle T.
  task automatic start_ld(input logic [4:0] a, input logic [1:0] em, input logic [9:0] vl,
                          input logic [6:0] sew, input logic [7:0] seed, output int t);
    bus.vd_data   = mkvec(seed);
    bus.vd_addr   = a;
    bus.emul      = em;
    bus.vl        = vl;
    bus.sew       = sew;
    bus.is_loaded = 1'b1;
    t = cyc;
  endtask

  // After capture: drop the level and scramble the inputs.
  task automatic garble;
    bus.is_loaded = 1'b0;
    bus.vd_data   = ~bus.vd_data;
    bus.vd_addr   = ~bus.vd_addr;
    bus.vl        = 10'd1;
    bus.sew       = 7'd8;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d events still pending, expected 0", nm, q.size());
      q.delete();
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.vrf_wr_en) begin
        if (q.size() == 0 || q[0].is_done) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_write: cyc %0d addr %0d, expected no write", cyc, bus.vrf_wr_addr);
        end else if (bus.vrf_ready) begin
          e = q.pop_front();
          n_vec++;
          if (cyc != e.cyc || bus.vrf_wr_addr !== e.addr || bus.vrf_wr_be !== e.be ||
              bus.vrf_wr_data !== e.data || bus.wb_busy !== 1'b1 || bus.wb_done !== 1'b0) begin
            n_bad++;
            $display("FAIL write: cyc %0d addr %0d be %h data_ok %0d busy %0b, expected cyc %0d addr %0d be %h",
                     cyc, bus.vrf_wr_addr, bus.vrf_wr_be, bus.vrf_wr_data === e.data,
                     bus.wb_busy, e.cyc, e.addr, e.be);
          end
        end else begin
          n_vec++;
          if (bus.vrf_wr_addr !== q[0].addr || bus.vrf_wr_be !== q[0].be ||
              bus.vrf_wr_data !== q[0].data) begin
            n_bad++;
            $display("FAIL stall_hold: cyc %0d addr %0d be %h data_ok %0d, expected addr %0d be %h",
                     cyc, bus.vrf_wr_addr, bus.vrf_wr_be, bus.vrf_wr_data === q[0].data,
                     q[0].addr, q[0].be);
          end
        end
      end
      if (bus.wb_done) begin
        n_vec++;
        if (q.size() == 0 || !q[0].is_done) begin
          n_bad++;
          $display("FAIL unexpected_done: cyc %0d, expected no wb_done", cyc);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || bus.wb_busy !== 1'b1 || bus.vrf_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL done: cyc %0d busy %0b wr_en %0b, expected cyc %0d busy 1 wr_en 0",
                     cyc, bus.wb_busy, bus.vrf_wr_en, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int t;
    bus.is_loaded = 1'b0;
    bus.vd_data   = '0;
    bus.vd_addr   = '0;
    bus.emul      = '0;
    bus.vl        = '0;
    bus.sew       = 7'd32;
    bus.vrf_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_wr_en", 64'(bus.vrf_wr_en), 64'd0);
    chk("rst_busy",  64'(bus.wb_busy),   64'd0);
    chk("rst_done",  64'(bus.wb_done),   64'd0);
    chk("rst_be",    64'(bus.vrf_wr_be), 64'd0);
    chk("rst_addr",  64'(bus.vrf_wr_addr), 64'd0);
    chk("rst_data",  64'(|bus.vrf_wr_data), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single register, full enables.
    start_ld(5'd3, 2'd0, 10'd16, 7'd32, 8'h11, t);
    push_wr(t+1, 5'd3, pat(8'h11, 0), ALL);
    push_done(t+2);
    tick(); garble();
    drain("single");

    // Group of 4 with two stall cycles on the 2nd write.
    start_ld(5'd9, 2'd2, 10'd64, 7'd32, 8'h22, t);
    push_wr(t+1, 5'd8,  pat(8'h22, 0), ALL);
    push_wr(t+4, 5'd9,  pat(8'h22, 1), ALL);
    push_wr(t+5, 5'd10, pat(8'h22, 2), ALL);
    push_wr(t+6, 5'd11, pat(8'h22, 3), ALL);
    push_done(t+7);
    tick(); garble();
    tick(); bus.vrf_ready = 1'b0;
    tick();
    tick(); bus.vrf_ready = 1'b1;
    drain("stall");

    // Tail masks.
    start_ld(5'd4, 2'd1, 10'd20, 7'd32, 8'h33, t);
    push_wr(t+1, 5'd4, pat(8'h33, 0), ALL);
    push_wr(t+2, 5'd5, pat(8'h33, 1), BE_V20);
    push_done(t+3);
    tick(); garble();
    drain("tail32");

    start_ld(5'd0, 2'd0, 10'd10, 7'd8, 8'h34, t);
    push_wr(t+1, 5'd0, pat(8'h34, 0), BE_10B);
    push_done(t+2);
    tick(); garble();
    drain("tail8");

    start_ld(5'd1, 2'd0, 10'd5, 7'd16, 8'h35, t);
    push_wr(t+1, 5'd1, pat(8'h35, 0), BE_10B);
    push_done(t+2);
    tick(); garble();
    drain("tail16");

    start_ld(5'd2, 2'd0, 10'd3, 7'd64, 8'h36, t);
    push_wr(t+1, 5'd2, pat(8'h36, 0), BE_12B);
    push_done(t+2);
    tick(); garble();
    drain("tail_sew_other");

    // Zero length: done only, busy for a single cycle.
    start_ld(5'd13, 2'd2, 10'd0, 7'd32, 8'h44, t);
    push_done(t+1);
    tick(); garble();
    chk("zero_busy_t1", 64'(bus.wb_busy), 64'd1);
    tick();
    chk("zero_busy_t2", 64'(bus.wb_busy), 64'd0);
    drain("zero");

    // Second edge during WRITE and level held across DONE are both ignored.
    start_ld(5'd7, 2'd1, 10'd32, 7'd32, 8'h55, t);
    push_wr(t+1, 5'd6, pat(8'h55, 0), ALL);
    push_wr(t+2, 5'd7, pat(8'h55, 1), ALL);
    push_done(t+3);
    tick(); garble();
    tick(); bus.is_loaded = 1'b1; bus.vd_data = mkvec(8'h66);
    repeat (4) tick();
    bus.is_loaded = 1'b0;
    drain("busy_edge");

    // Reset during the 2nd write of an 8-register group; level stays high so
    // release counts as a fresh edge and the group restarts at idx 0.
    start_ld(5'd17, 2'd3, 10'd128, 7'd32, 8'h77, t);
    push_wr(t+1, 5'd16, pat(8'h77, 0), ALL);
    tick(); bus.vd_data = mkvec(8'h88);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    chk("midrst_wr_en", 64'(bus.vrf_wr_en), 64'd0);
    chk("midrst_busy",  64'(bus.wb_busy),   64'd0);
    chk("midrst_done",  64'(bus.wb_done),   64'd0);
    for (int i = 0; i < 8; i++) push_wr(t+4+i, 5'(16+i), pat(8'h88, i), ALL);
    push_done(t+12);
    tick(); garble();
    drain("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
